// File: rtl/dds_pkg.sv
// Shared types and constants for the dds_core direct digital synthesiser.
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } mode_t;

    // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

endpackage

// File: rtl/dds_quarter_lut.sv
// Quarter-wave sine ROM with registered read; contents built at elaboration.
module dds_quarter_lut
    import dds_pkg::*;
#(
    parameter int PHASE_W = 10,
    parameter int DATA_W  = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PHASE_W-3:0]  addr,
    output logic [DATA_W-2:0]   value
);

    localparam int DEPTH = 2 ** (PHASE_W - 2);

    // Half-sample offset keeps the four quadrants exactly mirror-symmetric
    function automatic int lut_val(input int unsigned i);
        real amp;
        real ang;
        amp = real'((2 ** (DATA_W - 1)) - 1);
        ang = 2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / real'(2 ** PHASE_W);
        return $rtoi(amp * $sin(ang));
    endfunction

    logic [DATA_W-2:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int VAL = lut_val(i);
        assign rom[i] = (DATA_W - 1)'(VAL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) value <= '0;
        else       value <= rom[addr];
    end

endmodule

// File: rtl/dds_core.sv
// Three-stage DDS: accumulator/offset, quarter-wave LUT, waveform mux.
// Optional phase dithering is enabled by defining PHASE_DITHER_EN.
module dds_core
    import dds_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int PHASE_W = 10,
    parameter int DATA_W  = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               fcw_load,
    input  logic [ACC_W-1:0]   fcw,
    input  logic [PHASE_W-1:0] phase_offset,
    input  logic [1:0]         mode,
    output logic [PHASE_W-1:0] phase,
    output logic [DATA_W-1:0]  data,
    output logic               data_valid,
    output logic               wrap
);

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   fcw_reg;
    logic [ACC_W:0]     acc_sum;
    logic [PHASE_W-1:0] acc_trunc;

    assign acc_sum = {1'b0, acc} + {1'b0, fcw_reg};

`ifdef PHASE_DITHER_EN
    localparam int DITH_W = (ACC_W - PHASE_W < 16) ? ACC_W - PHASE_W : 16;
    logic [15:0]      lfsr;
    logic [ACC_W-1:0] dith;
    logic [ACC_W-1:0] dith_sum;

    always_comb begin
        dith = '0;
        for (int unsigned i = 0; i < int unsigned'(DITH_W); i++) dith[i] = lfsr[i];
    end

    assign dith_sum  = acc + dith;
    assign acc_trunc = dith_sum[ACC_W-1 -: PHASE_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       lfsr <= LFSR_SEED;
        else if (enable) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
    end
`else
    assign acc_trunc = acc[ACC_W-1 -: PHASE_W];
`endif

    logic [PHASE_W-1:0] p1, p2;
    mode_t              mode1, mode2;
    logic               v1, v2, wrap1, wrap2;
    logic [PHASE_W-3:0] lut_addr;
    logic [DATA_W-2:0]  lut_value;

    // S1: fcw register, accumulator, offset phase
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fcw_reg <= '0;
            acc     <= '0;
            p1      <= '0;
            mode1   <= MODE_SINE;
            wrap1   <= 1'b0;
            v1      <= 1'b0;
        end else begin
            if (fcw_load) fcw_reg <= fcw;
            v1 <= enable;
            if (enable) begin
                acc   <= acc_sum[ACC_W-1:0];
                p1    <= acc_trunc + phase_offset;
                mode1 <= mode_t'(mode);
                wrap1 <= acc_sum[ACC_W];
            end
        end
    end

    assign lut_addr = p1[PHASE_W-2] ? ~p1[PHASE_W-3:0] : p1[PHASE_W-3:0];

    dds_quarter_lut #(
        .PHASE_W (PHASE_W),
        .DATA_W  (DATA_W)
    ) u_lut (
        .clock (clock),
        .reset (reset),
        .addr  (lut_addr),
        .value (lut_value)
    );

    // S2: forward the sample context alongside the registered LUT read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p2    <= '0;
            mode2 <= MODE_SINE;
            v2    <= 1'b0;
            wrap2 <= 1'b0;
        end else begin
            p2    <= p1;
            mode2 <= mode1;
            v2    <= v1;
            wrap2 <= wrap1;
        end
    end

    logic [PHASE_W-2:0] tri_t;
    logic [DATA_W-1:0]  sample;

    assign tri_t = p2[PHASE_W-1] ? ~p2[PHASE_W-2:0] : p2[PHASE_W-2:0];

    // Sine: upper half is M+lut, lower half is M-1-lut
    always_comb begin
        sample = '0;
        unique case (mode2)
            MODE_SINE:   sample = p2[PHASE_W-1] ? {1'b0, ~lut_value} : {1'b1, lut_value};
            MODE_SQUARE: sample = p2[PHASE_W-1] ? '0 : '1;
            MODE_SAW:    sample = DATA_W'(p2) << (DATA_W - PHASE_W);
            MODE_TRI:    sample = DATA_W'({tri_t, 1'b0}) << (DATA_W - PHASE_W);
        endcase
    end

    // S3: bubbles leave phase/data untouched
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            data_valid <= v2;
            wrap       <= v2 & wrap2;
            if (v2) begin
                phase <= p2;
                data  <= sample;
            end
        end
    end

endmodule
